// File: rtl/odin_aer_pkg.sv
// Shared register map, status bit layout and handshake FSM encoding
// for the AER-output-to-OBI bridge.
package odin_aer_pkg;

    localparam logic [31:0] AER_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] AER_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] AER_CTRL_OFS   = 32'h0000_0008;

    localparam int unsigned STAT_OVF_BIT     = 31;
    localparam int unsigned STAT_FULL_BIT    = 30;
    localparam int unsigned STAT_EMPTY_BIT   = 29;
    localparam int unsigned STAT_COUNT_W     = 16;
    localparam int unsigned DATA_VALID_BIT   = 31;
    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } aer_fsm_e;

    // Word index of a register offset; only address bits [3:2] are decoded.
    function automatic logic [1:0] reg_index(input logic [31:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/aer_evt_fifo.sv
// Event FIFO with first-word-fall-through read data, flush, and a drop
// indication for pushes that find no free slot.
module aer_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
    assign o_drop    = i_push && !i_flush && w_full && !w_do_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/aer_out_to_obi.sv
// Receives tinyODIN output spikes over a 4-phase AER handshake, buffers them,
// and exposes them to the CPU through an OBI slave with pop-on-read DATA.
module aer_out_to_obi
    import odin_aer_pkg::*;
#(
    parameter int unsigned NUM_NEU     = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               obi_req_i,
    input  logic               obi_we_i,
    input  logic [31:0]        obi_addr_i,
    input  logic [3:0]         obi_be_i,
    input  logic [31:0]        obi_wdata_i,
    output logic               obi_gnt_o,
    output logic               obi_rvalid_o,
    output logic [31:0]        obi_rdata_o,
    input  logic [NUM_NEU-1:0] AEROUT_ADDR,
    input  logic               AEROUT_REQ,
    output logic               AEROUT_ACK,
    output logic               irq_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] REG_DATA   = reg_index(AER_DATA_OFS);
    localparam logic [1:0] REG_STATUS = reg_index(AER_STATUS_OFS);
    localparam logic [1:0] REG_CTRL   = reg_index(AER_CTRL_OFS);

    logic [SYNC_STAGES-1:0] r_req_sync;
    aer_fsm_e               r_state;
    logic                   r_ack;
    logic                   r_ovf;
    logic                   r_irq;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;

    logic                   w_req_s;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_flush;
    logic                   w_clr_ovf;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    logic [NUM_NEU-1:0]     w_fifo_rdata;
    logic [1:0]             w_reg_sel;
    logic [31:0]            w_rdata_nxt;
    logic                   w_unused_bits;

    assign w_unused_bits = ^{obi_be_i, obi_addr_i[31:4], obi_addr_i[1:0], obi_wdata_i[31:2]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], AEROUT_REQ};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];

    // Exactly one push per REQ high phase: the push fires on the IDLE->ACK_HI step.
    assign w_push = (r_state == IDLE) && w_req_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_s) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    aer_evt_fifo #(
        .WIDTH (NUM_NEU),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (AEROUT_ADDR),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    assign w_reg_sel = reg_index(obi_addr_i);

    always_comb begin
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_clr_ovf   = 1'b0;
        w_rdata_nxt = '0;
        if (obi_req_i) begin
            if (obi_we_i) begin
                if (w_reg_sel == REG_CTRL) begin
                    w_flush   = obi_wdata_i[CTRL_FLUSH_BIT];
                    w_clr_ovf = obi_wdata_i[CTRL_CLR_OVF_BIT];
                end
            end else begin
                case (w_reg_sel)
                    REG_DATA: begin
                        if (!w_empty) begin
                            w_pop                       = 1'b1;
                            w_rdata_nxt[DATA_VALID_BIT] = 1'b1;
                            w_rdata_nxt[NUM_NEU-1:0]    = w_fifo_rdata;
                        end
                    end
                    REG_STATUS: begin
                        w_rdata_nxt[STAT_OVF_BIT]       = r_ovf;
                        w_rdata_nxt[STAT_FULL_BIT]      = w_full;
                        w_rdata_nxt[STAT_EMPTY_BIT]     = w_empty;
                        w_rdata_nxt[STAT_COUNT_W-1:0]   = STAT_COUNT_W'(w_count);
                    end
                    default: w_rdata_nxt = '0;
                endcase
            end
        end
    end

    // A drop in the same cycle as clear-overflow keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            r_irq    <= !w_empty;
            r_rvalid <= obi_req_i;
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = r_rvalid;
    assign obi_rdata_o  = r_rdata;
    assign AEROUT_ACK   = r_ack;
    assign irq_o        = r_irq;

endmodule
